// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the programmable clock-divider bank.
package clkdiv_pkg;

  localparam int MIN_DIV        = 2;
  localparam int CLKDIV_DIV_W   = 8;
  localparam int CLKDIV_DEF_DIV = 2;

  typedef logic [CLKDIV_DIV_W-1:0] div_t;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: period counter, posedge/negedge phase flops and a
// pending-divisor register that is only applied on a period boundary.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int DIV_W   = CLKDIV_DIV_W,
  parameter int DEF_DIV = CLKDIV_DEF_DIV
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             pend,
  output logic             clk_out
);

  logic [DIV_W-1:0] n_cur_q, n_cur_d;
  logic [DIV_W-1:0] n_pend_q, n_pend_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cnt_inc;
  logic             pend_q, pend_d;
  logic             run_q, run_d;
  logic             pos_q, pos_d;
  logic             neg_q;
  logic             start;
  logic             at_end;

  always_comb begin
    start    = ~run_q & en;
    at_end   = run_q & (cnt_q == (n_cur_q - 1'b1));
    cnt_inc  = cnt_q + 1'b1;
    run_d    = run_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    n_cur_d  = n_cur_q;
    n_pend_d = n_pend_q;
    pend_d   = pend_q;

    if (start) begin
      run_d = 1'b1;
      cnt_d = '0;
      pos_d = 1'b1;
      // An update that landed on the stopping edge is applied on restart.
      if (pend_q) begin
        n_cur_d = n_pend_q;
        pend_d  = 1'b0;
      end
    end else if (run_q) begin
      if (at_end) begin
        cnt_d = '0;
        if (pend_q) begin
          n_cur_d = n_pend_q;
          pend_d  = 1'b0;
        end
        run_d = en;
        pos_d = en;
      end else begin
        cnt_d = cnt_inc;
        pos_d = (cnt_inc < (n_cur_q >> 1));
      end
    end

    // The top only asserts load while pend_q is clear.
    if (load) begin
      if (run_q) begin
        n_pend_d = load_div;
        pend_d   = 1'b1;
      end else begin
        n_cur_d = load_div;
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      n_cur_q  <= DIV_W'(DEF_DIV);
      n_pend_q <= DIV_W'(DEF_DIV);
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      run_q    <= 1'b0;
      pos_q    <= 1'b0;
    end else begin
      n_cur_q  <= n_cur_d;
      n_pend_q <= n_pend_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      run_q    <= run_d;
      pos_q    <= pos_d;
    end
  end

  // Half-cycle delayed copy stretches the high phase for odd divisors.
  always_ff @(negedge clk or negedge resetb) begin
    if (!resetb) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  assign clk_out = pos_q | (n_cur_q[0] & neg_q);
  assign pend    = pend_q;

endmodule

// File: rtl/clkdiv_bank.sv
// Bank of NCH run-time programmable 50% duty-cycle clock dividers.
// cfg handshake: a request transfers on a posedge where cfg_valid & cfg_ready.
module clkdiv_bank
  import clkdiv_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DIV_W   = CLKDIV_DIV_W,
  parameter int DEF_DIV = CLKDIV_DEF_DIV,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [NCH-1:0]   ch_en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic [NCH-1:0]   pend,
  output logic [NCH-1:0]   clk_out
);

  logic           ready_w;
  logic           accept;
  logic           ch_ok;
  logic           div_ok;
  logic [NCH-1:0] load;

  always_comb begin
    ch_ok   = (int'(cfg_ch) < NCH);
    div_ok  = (cfg_div >= DIV_W'(MIN_DIV));
    ready_w = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (int'(cfg_ch) == i) ready_w = ~pend[i];
    end
    accept = cfg_valid & ready_w;
    load   = '0;
    for (int i = 0; i < NCH; i++) begin
      load[i] = accept & ch_ok & div_ok & (int'(cfg_ch) == i);
    end
  end

  assign cfg_ready = ready_w;

  // Rejected requests are still consumed; only the error pulse records them.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= accept & ~(ch_ok & div_ok);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clkdiv_chan #(
      .DIV_W  (DIV_W),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .clk     (clk),
      .resetb  (resetb),
      .en      (ch_en[g]),
      .load    (load[g]),
      .load_div(cfg_div),
      .pend    (pend[g]),
      .clk_out (clk_out[g])
    );
  end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Directed bench for clkdiv_bank: waveform shape in half-cycles, update timing,
// handshake back-pressure, error pulses, stop behaviour and async reset.
module tb_clkdiv_bank;

  localparam int NCH   = 5;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             resetb;
  logic [NCH-1:0]   ch_en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_err;
  logic [NCH-1:0]   pend;
  logic [NCH-1:0]   clk_out;

  int tests  = 0;
  int failed = 0;
  int hi, lo, highs;
  bit fneg;

  clkdiv_bank #(.NCH(NCH), .DIV_W(DIV_W), .DEF_DIV(2)) dut (
    .clk      (clk),
    .resetb   (resetb),
    .ch_en    (ch_en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_err  (cfg_err),
    .pend     (pend),
    .clk_out  (clk_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic half();
    @(posedge clk or negedge clk);
    #1;
  endtask

  task automatic pos_step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a rising edge of clk_out[ch]; it must follow a posedge.
  task automatic wait_rise(input int ch, input string tag);
    logic prev;
    bit   ok;
    ok   = 1'b0;
    prev = clk_out[ch];
    for (int k = 0; k < 200; k++) begin
      half();
      if (!prev && clk_out[ch]) begin
        ok = 1'b1;
        break;
      end
      prev = clk_out[ch];
    end
    check(tag, 32'(ok), 1);
    check({tag, "_align"}, 32'(clk), 1);
  endtask

  // Called just after a rising edge; returns high/low widths in half-cycles
  // and whether the falling edge followed a negedge of clk.
  task automatic meas(input int ch, output int h, output int l, output bit fn);
    h  = 0;
    l  = 0;
    fn = 1'b0;
    for (int k = 0; k < 600; k++) begin
      half();
      h++;
      if (!clk_out[ch]) break;
    end
    fn = (clk == 1'b0);
    for (int k = 0; k < 600; k++) begin
      half();
      l++;
      if (clk_out[ch]) break;
    end
  endtask

  initial begin
    resetb    = 1'b1;
    ch_en     = '0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    #1 resetb = 1'b0;
    #1;
    check("rst_clk_out", 32'(clk_out), 0);
    check("rst_pend", 32'(pend), 0);
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    check("rst_cfg_err", 32'(cfg_err), 0);
    repeat (2) @(negedge clk);
    resetb = 1'b1;

    // Start channel 0 at the default divisor.
    pos_step();
    check("start_pre", 32'(clk_out[0]), 0);
    ch_en[0] = 1'b1;
    pos_step();
    check("start_rise", 32'(clk_out[0]), 1);
    meas(0, hi, lo, fneg);
    check("div2_hi", hi, 2);
    check("div2_lo", lo, 2);
    check("div2_pend", 32'(pend), 0);
    check("div2_ready", 32'(cfg_ready), 1);

    // Channel 1: divisor 5 loaded while stopped, then 20 periods.
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd5;
    pos_step();
    cfg_valid = 1'b0;
    check("direct_load_pend", 32'(pend[1]), 0);
    ch_en[1] = 1'b1;
    pos_step();
    check("odd_rise", 32'(clk_out[1]), 1);
    for (int p = 0; p < 20; p++) begin
      meas(1, hi, lo, fneg);
      check("odd_hi", hi, 5);
      check("odd_lo", lo, 5);
      check("odd_fall_neg", 32'(fneg), 1);
    end

    // Channel 0 to divisor 7; a second request while pending is held off.
    wait_rise(0, "rise0_a");
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd7;
    pos_step();
    check("pend_set", 32'(pend[0]), 1);
    check("bp_ready", 32'(cfg_ready), 0);
    cfg_div = 8'd9;
    pos_step();
    cfg_valid = 1'b0;
    check("pend_clr", 32'(pend[0]), 0);
    check("rise7", 32'(clk_out[0]), 1);
    meas(0, hi, lo, fneg);
    check("div7_hi", hi, 7);
    check("div7_lo", lo, 7);

    // Change to 4 as cnt reaches 2; boundary is 5 posedges later.
    pos_step();
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd4;
    pos_step();
    cfg_valid = 1'b0;
    check("chg_pend", 32'(pend[0]), 1);
    for (int k = 0; k < 4; k++) begin
      pos_step();
      check("chg_pend_hold", 32'(pend[0]), 1);
    end
    pos_step();
    check("chg_pend_clr", 32'(pend[0]), 0);
    check("chg_rise", 32'(clk_out[0]), 1);
    meas(0, hi, lo, fneg);
    check("div4_hi", hi, 4);
    check("div4_lo", lo, 4);

    // Rejected requests: divisor too small, channel out of range.
    cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd1;
    #1;
    check("err_div_ready", 32'(cfg_ready), 1);
    pos_step();
    cfg_valid = 1'b0;
    check("err_div_pulse", 32'(cfg_err), 1);
    check("err_div_pend", 32'(pend), 0);
    pos_step();
    check("err_div_end", 32'(cfg_err), 0);
    cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_div = 8'd6;
    #1;
    check("err_ch_ready", 32'(cfg_ready), 1);
    pos_step();
    cfg_valid = 1'b0;
    check("err_ch_pulse", 32'(cfg_err), 1);
    check("err_ch_pend", 32'(pend), 0);
    pos_step();
    check("err_ch_end", 32'(cfg_err), 0);
    ch_en[2] = 1'b1;
    pos_step();
    check("ch2_rise", 32'(clk_out[2]), 1);
    meas(2, hi, lo, fneg);
    check("ch2_hi", hi, 2);
    check("ch2_lo", lo, 2);

    // Stop channel 0 (divisor 4) in its high phase.
    wait_rise(0, "rise0_b");
    pos_step();
    check("stop_pre", 32'(clk_out[0]), 1);
    ch_en[0] = 1'b0;
    @(negedge clk);
    #1;
    check("stop_hi_kept", 32'(clk_out[0]), 1);
    pos_step();
    check("stop_hi_end", 32'(clk_out[0]), 0);
    highs = 0;
    for (int k = 0; k < 16; k++) begin
      half();
      if (clk_out[0]) highs++;
    end
    check("stop_hold_low", highs, 0);

    // Update accepted on channel 1's boundary edge applies one period later.
    wait_rise(1, "rise1_a");
    for (int k = 0; k < 4; k++) pos_step();
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd3;
    pos_step();
    cfg_valid = 1'b0;
    check("same_edge_pend", 32'(pend[1]), 1);
    check("same_edge_rise", 32'(clk_out[1]), 1);
    meas(1, hi, lo, fneg);
    check("same_edge_old_hi", hi, 5);
    check("same_edge_old_lo", lo, 5);
    check("same_edge_pend_clr", 32'(pend[1]), 0);
    meas(1, hi, lo, fneg);
    check("div3_hi", hi, 3);
    check("div3_lo", lo, 3);
    check("div3_fall_neg", 32'(fneg), 1);

    // Async reset mid-period on channel 3 running at 9.
    cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_div = 8'd9;
    pos_step();
    cfg_valid = 1'b0;
    ch_en[3] = 1'b1;
    pos_step();
    check("div9_rise", 32'(clk_out[3]), 1);
    for (int k = 0; k < 3; k++) pos_step();
    check("div9_cnt3_high", 32'(clk_out[3]), 1);
    #2 resetb = 1'b0;
    #1;
    check("arst_clk_out", 32'(clk_out), 0);
    check("arst_pend", 32'(pend), 0);
    check("arst_ready", 32'(cfg_ready), 1);
    check("arst_err", 32'(cfg_err), 0);
    ch_en = '0;
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    pos_step();
    ch_en[3] = 1'b1;
    ch_en[1] = 1'b1;
    pos_step();
    check("arst_rise3", 32'(clk_out[3]), 1);
    check("arst_rise1", 32'(clk_out[1]), 1);
    meas(3, hi, lo, fneg);
    check("arst_def3_hi", hi, 2);
    check("arst_def3_lo", lo, 2);
    wait_rise(1, "rise1_b");
    meas(1, hi, lo, fneg);
    check("arst_def1_hi", hi, 2);
    check("arst_def1_lo", lo, 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/clkdiv_bank.md
# clkdiv_bank

Multi-channel, parametrised integer-N clock divider with 50 % duty cycle for both even and odd divisors. Each channel's divisor can be changed at run time through a valid/ready configuration port. New divisors and enable changes take effect only at the channel's period boundary, so the output never glitches or produces a runt pulse. The block sits between the PLL/reference clock and the hash-core clock domains, and replaces per-core single-channel dividers with one programmable bank.

## Interface
- `NCH`, 4: number of independent output channels (1..16).
- `DIV_W`, 8: divisor width in bits. Legal divisor range is 2..2^DIV_W−1.
- `DEF_DIV`, 2: divisor loaded into every channel at reset. Must be ≥ 2.
- `clk`  in  1: source clock. Both edges are used.
- `resetb`  in  1: reset, asynchronous, active-low.
- `ch_en`  in  NCH: per-channel run enable. Must be synchronous to `clk`.
- `cfg_valid`  in  1: configuration request.
- `cfg_ready`  out  1: the request can be accepted this cycle.
- `cfg_ch`  in  $clog2(NCH) (min 1): target channel.
- `cfg_div`  in  DIV_W: new divisor.
- `cfg_err`  out  1: one-cycle pulse when a request is rejected.
- `pend`  out  NCH: per-channel flag, a divisor update is waiting for the period boundary.
- `clk_out`  out  NCH: divided clocks.

## Operation
- **Per-channel state:**
  - `n_cur`: DIV_W bits.
  - `n_pend`: DIV_W bits.
  - `pend`.
  - `cnt`: DIV_W bits, counting 0..n_cur−1 on posedge `clk`.
  - `pos_q`: posedge flop.
  - `neg_q`: negedge copy of `pos_q`.
  - `run`.
- **Waveform:**
  - `pos_q` is high while `cnt < n_cur>>1`.
  - `clk_out = pos_q | (n_cur[0] & neg_q)`.
  - High time is exactly n_cur/2 `clk` periods; low time is the same.
- **Period boundary:** the posedge at which `run` is set and `cnt == n_cur−1`. At that edge `cnt` wraps to 0.
- **Handshake:**
  - A request is accepted on a posedge where `cfg_valid & cfg_ready`.
  - `cfg_ready = ~pend[cfg_ch]`. The value is combinational from `cfg_ch`.
  - If `cfg_div < 2` or `cfg_ch ≥ NCH`: the request is accepted, `cfg_err` pulses on the next cycle, and no state changes.
  - Otherwise, if the channel is running: `n_pend <= cfg_div` and `pend <= 1`.
  - Otherwise, if the channel is not running: `n_cur <= cfg_div` directly, and `pend` stays 0.
- **Applying an update:** at the period boundary, if `pend` is set then `n_cur <= n_pend`, `pend <= 0`, and the new period starts at `cnt = 0` with the new divisor.
- **Enable:**
  - **Start:** `ch_en` rising while stopped gives `run <= 1`, `cnt <= 0`, `pos_q <= 1` on the next posedge.
  - **Stop:** `ch_en` low while running causes a stop at the next period boundary: `run <= 0`, `pos_q <= 0`, `cnt <= 0`. `clk_out` stays low.
  - **Re-enable:** if `ch_en` returns high before the boundary, the stop is cancelled.
- **Simultaneous events:**
  - A request accepted on the same edge as that channel's boundary is applied at the following boundary, not the current one.
  - A stop and a pending update on the same boundary: the update is applied, then the channel stops.
- **Reset values:**
  - `n_cur = DEF_DIV`.
  - `n_pend = DEF_DIV`.
  - `pend = 0`, `cnt = 0`, `pos_q = 0`, `neg_q = 0`, `run = 0`.
  - Outputs: `clk_out = 0`, `cfg_ready = 1`, `cfg_err = 0`.
  - Reset asserted mid-period forces these values immediately (asynchronously). Any partial pulse is truncated; this is acceptable only under reset.

## Timing
- **Start latency:** 1 posedge from `ch_en` high to `clk_out` rising.
- **Update latency:** the new divisor is visible from the first boundary after the accept edge. Worst case is n_cur+1 `clk` cycles.
- **`pend`:** high from the cycle after accept until the cycle after apply.
- **`cfg_err`:** registered, high for exactly 1 cycle.
- **Edge alignment:**
  - `clk_out` rising edges align to posedge `clk`.
  - For odd n_cur, falling edges align to negedge `clk`.
  - No combinational path from `clk` to `clk_out`.
- **Maximum divisor:** 2^DIV_W−1. `cnt` compares use full DIV_W width and never overflow.

## Structure
- **Package `clkdiv_pkg`:**
  - `MIN_DIV = 2`.
  - Default `DIV_W` and `DEF_DIV`.
  - Typedef `div_t` (logic [DIV_W−1:0]).
- **Sub-module `clkdiv_chan`:**
  - Holds one channel: counter, `pos_q`/`neg_q`, `run`, pending register.
  - Ports: `clk`, `resetb`, `en`, `load`, `load_div`, `pend`, `clk_out`.
- **Top level `clkdiv_bank`:**
  - Generate loop over NCH channels.
  - Request decode and range check, `cfg_err` flop, `cfg_ready` mux.

## Test plan
- **Reset and start:** release reset, set `ch_en[0]=1`. `clk_out[0]` rises 1 posedge later and shows period 2, high 1 cycle. `pend=0`, `cfg_ready=1`.
- **Odd divisor:** set channel 1 to divisor 5 while stopped, then enable. High 2.5 `clk` periods, low 2.5, repeated over 20 periods. Falling edges on negedge.
- **Glitch-free change:** channel 0 running at 7. Accept divisor 4 at cnt=2. `pend` stays high until the boundary 5 cycles later. The next period is exactly 4, and no pulse is shorter than 2 `clk` periods.
- **Back-pressure and error:**
  - A second request to a pending channel sees `cfg_ready=0`.
  - `cfg_div=1` gives a 1-cycle `cfg_err` and no divisor change.
  - `cfg_ch=NCH` gives `cfg_err`.
- **Stop and same-edge update:** `ch_en` drops mid-high-phase. The output completes its period, then holds low. An update accepted on a boundary edge applies one period later.
- **Async reset mid-period:** assert `resetb=0` at cnt=3 with divisor 9. All outputs go to reset values immediately, and all channels return to `DEF_DIV`.
